// File: rtl/mem_stage_pkg.sv
// Shared pipeline constants and bus layouts for the memory stage and its neighbours.
// Bus structs pack MSB-first, so field order matches the wire layout exactly.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_ES_BUS_WD = 39;

  // Load flavours; encodings 5-7 are unassigned and behave as ld.w.
  localparam logic [2:0] MEM_OP_LD_W  = 3'd0;
  localparam logic [2:0] MEM_OP_LD_B  = 3'd1;
  localparam logic [2:0] MEM_OP_LD_H  = 3'd2;
  localparam logic [2:0] MEM_OP_LD_BU = 3'd3;
  localparam logic [2:0] MEM_OP_LD_HU = 3'd4;

  typedef enum logic [1:0] {
    MS_EMPTY,
    MS_WAIT_RESP,
    MS_READY
  } ms_state_e;

  typedef struct packed {
    logic        req_issued;
    logic [2:0]  mem_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic        fwd_we;
    logic        fwd_blocked;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_to_es_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a 32-bit load word and sign- or
// zero-extends it according to the load flavour.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (mem_op)
      MEM_OP_LD_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LD_H:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LD_BU: load_data = {24'd0, byte_sel};
      MEM_OP_LD_HU: load_data = {16'd0, half_sel};
      default:      load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, waits for its data-SRAM response,
// aligns load data and hands the result to writeback and the forwarding network.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = mem_stage_pkg::ES_TO_MS_BUS_WD,
  parameter int MS_TO_WS_BUS_WD = mem_stage_pkg::MS_TO_WS_BUS_WD
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic                                   ms_allowin,
  input  logic                                   es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0]             es_to_ms_bus,
  input  logic                                   ws_allowin,
  output logic                                   ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0]             ms_to_ws_bus,
  output logic [mem_stage_pkg::MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
  input  logic                                   data_sram_data_ok,
  input  logic [31:0]                            data_sram_rdata
);

  import mem_stage_pkg::*;

  es_to_ms_t   in_bus;
  es_to_ms_t   ms_bus_r;
  ms_to_ws_t   ws_bus;
  ms_to_es_t   es_bus;
  ms_state_e   state;
  ms_state_e   state_nxt;
  ms_state_e   load_state;
  logic        ms_valid;
  logic        ms_ready_go;
  logic        accept;
  logic        buf_load;
  logic [31:0] data_buf;
  logic [31:0] mem_data;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign in_bus         = es_to_ms_t'(es_to_ms_bus);
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign accept         = es_to_ms_valid && ms_allowin;
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign load_state     = in_bus.req_issued ? MS_WAIT_RESP : MS_READY;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MS_EMPTY;
    else       state <= state_nxt;
  end

  // Hand-off and accept may coincide, so the slot refills without a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      MS_EMPTY:
        if (accept) state_nxt = load_state;
      MS_WAIT_RESP:
        if (data_sram_data_ok) begin
          if (ws_allowin) state_nxt = accept ? load_state : MS_EMPTY;
          else            state_nxt = MS_READY;
        end
      MS_READY:
        if (ws_allowin) state_nxt = accept ? load_state : MS_EMPTY;
      default:
        state_nxt = MS_EMPTY;
    endcase
  end

  always_comb begin
    ms_ready_go = (state == MS_READY) || (state == MS_WAIT_RESP && data_sram_data_ok);
    buf_load    = (state == MS_WAIT_RESP) && data_sram_data_ok && !ws_allowin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= es_to_ms_valid;
  end

  // NOTE: pure datapath registers carry no reset; ms_valid/state gate every use of them.
  always_ff @(posedge clk) begin
    if (accept)   ms_bus_r <= in_bus;
    if (buf_load) data_buf <= data_sram_rdata;
  end

  // A response that arrived while writeback stalled lives in data_buf.
  assign mem_data = (state == MS_READY && ms_bus_r.req_issued) ? data_buf : data_sram_rdata;

  load_align u_load_align (
    .mem_op    (ms_bus_r.mem_op),
    .addr_lo   (ms_bus_r.alu_result[1:0]),
    .rdata     (mem_data),
    .load_data (load_data)
  );

  assign final_result = ms_bus_r.res_from_mem ? load_data : ms_bus_r.alu_result;

  always_comb begin
    ws_bus.reg_we       = ms_bus_r.gr_we;
    ws_bus.dest         = ms_bus_r.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = ms_bus_r.pc;

    es_bus.fwd_we       = ms_valid && ms_bus_r.gr_we;
    es_bus.fwd_blocked  = ms_valid && ms_bus_r.res_from_mem && !ms_ready_go;
    es_bus.dest         = ms_bus_r.dest;
    es_bus.final_result = final_result;
  end

  assign ms_to_ws_bus = ws_bus;
  assign ms_to_es_bus = es_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, aligned loads, stalls,
// spurious responses, back-to-back hand-off and reset during a pending load.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_es_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_es_bus      (ms_to_es_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        ws_reg_we, fwd_we, fwd_blocked;
  logic [31:0] ws_result, ws_pc, fwd_result;
  assign ws_reg_we   = ms_to_ws_bus[69];
  assign ws_result   = ms_to_ws_bus[63:32];
  assign ws_pc       = ms_to_ws_bus[31:0];
  assign fwd_we      = ms_to_es_bus[38];
  assign fwd_blocked = ms_to_es_bus[37];
  assign fwd_result  = ms_to_es_bus[31:0];

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [74:0] mk(input logic req, input logic [2:0] op, input logic rfm,
                                     input logic we, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {req, op, rfm, we, dest, alu, pc};
  endfunction

  // One cycle: drive 1 ns after the rising edge, outputs settle for sampling 2 ns later.
  task automatic cyc(input logic ev, input logic [74:0] bus, input logic wa,
                     input logic dok, input logic [31:0] rd);
    @(posedge clk);
    #1;
    es_to_ms_valid    = ev;
    es_to_ms_bus      = bus;
    ws_allowin        = wa;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    #2;
  endtask

  // Load whose response arrives one cycle after accept, with writeback ready.
  task automatic fast_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp);
    cyc(1'b1, mk(1'b1, op, 1'b1, 1'b1, 5'd7, addr, 32'h0000_0200), 1'b1, 1'b0, 32'h0);
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check({tag, "_wait_valid"},   70'(ms_to_ws_valid), 70'(0));
    check({tag, "_wait_blocked"}, 70'(fwd_blocked),    70'(1));
    check({tag, "_wait_fwd_we"},  70'(fwd_we),         70'(1));
    check({tag, "_wait_allowin"}, 70'(ms_allowin),     70'(0));
    cyc(1'b0, '0, 1'b1, 1'b1, rd);
    check({tag, "_valid"},   70'(ms_to_ws_valid), 70'(1));
    check({tag, "_result"},  70'(ws_result),      70'(exp));
    check({tag, "_fwd_res"}, 70'(fwd_result),     70'(exp));
    check({tag, "_unblock"}, 70'(fwd_blocked),    70'(0));
    check({tag, "_allowin"}, 70'(ms_allowin),     70'(1));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check({tag, "_drained"}, 70'(ms_to_ws_valid), 70'(0));
  endtask

  initial begin
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #3;
    check("rst_valid",   70'(ms_to_ws_valid), 70'(0));
    check("rst_allowin", 70'(ms_allowin),     70'(1));
    check("rst_fwd_we",  70'(fwd_we),         70'(0));
    check("rst_blocked", 70'(fwd_blocked),    70'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // ALU op flows straight through in one cycle.
    cyc(1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000), 1'b1, 1'b0, 32'h0);
    check("alu_accept_allowin", 70'(ms_allowin),     70'(1));
    check("alu_accept_valid",   70'(ms_to_ws_valid), 70'(0));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("alu_valid",   70'(ms_to_ws_valid), 70'(1));
    check("alu_bus",     ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000});
    check("alu_fwd",     70'(ms_to_es_bus), 70'({1'b1, 1'b0, 5'd5, 32'h1234_5678}));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("alu_drained", 70'(ms_to_ws_valid), 70'(0));

    // Back-to-back ALU ops: one per cycle, allowin never drops.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, 5'(i + 1), 32'(i) * 32'h1111_1111, 32'h100 + 32'(4 * i)),
          1'b1, 1'b0, 32'h0);
      check("b2b_allowin", 70'(ms_allowin), 70'(1));
      if (i > 0) begin
        check("b2b_valid", 70'(ms_to_ws_valid), 70'(1));
        check("b2b_pc",    70'(ws_pc),     70'(32'h100 + 32'(4 * (i - 1))));
        check("b2b_res",   70'(ws_result), 70'(32'(i - 1) * 32'h1111_1111));
      end
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("b2b_last_pc", 70'(ws_pc), 70'(32'h110));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("b2b_drained", 70'(ms_to_ws_valid), 70'(0));

    fast_load("ldb",  3'd1, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
    fast_load("ldbu", 3'd3, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
    fast_load("ldh",  3'd2, 32'h0000_1002, 32'h80FF_0000, 32'hFFFF_80FF);

    // ld.hu with a slow response and a stalled writeback: result must come from data_buf.
    cyc(1'b1, mk(1'b1, 3'd4, 1'b1, 1'b1, 5'd8, 32'h0000_2002, 32'h0000_0240), 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
      check("ldhu_wait_blocked", 70'(fwd_blocked),    70'(1));
      check("ldhu_wait_valid",   70'(ms_to_ws_valid), 70'(0));
    end
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h80FF_1234);
    check("ldhu_resp_valid",   70'(ms_to_ws_valid), 70'(1));
    check("ldhu_resp_result",  70'(ws_result),      70'(32'h0000_80FF));
    check("ldhu_resp_allowin", 70'(ms_allowin),     70'(0));
    cyc(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("ldhu_spurious_res", 70'(ws_result),      70'(32'h0000_80FF));
    check("ldhu_hold_blocked", 70'(fwd_blocked),    70'(0));
    cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
    check("ldhu_hold_res",     70'(ws_result),      70'(32'h0000_80FF));
    check("ldhu_hold_valid",   70'(ms_to_ws_valid), 70'(1));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h5555_AAAA);
    check("ldhu_emit_valid",   70'(ms_to_ws_valid), 70'(1));
    check("ldhu_emit_bus",     ms_to_ws_bus, {1'b1, 5'd8, 32'h0000_80FF, 32'h0000_0240});
    check("ldhu_emit_allowin", 70'(ms_allowin),     70'(1));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("ldhu_drained",      70'(ms_to_ws_valid), 70'(0));

    // Spurious data_ok while empty.
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h1234_5678);
    check("spur_empty_valid",   70'(ms_to_ws_valid), 70'(0));
    check("spur_empty_allowin", 70'(ms_allowin),     70'(1));
    check("spur_empty_fwd_we",  70'(fwd_we),         70'(0));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("spur_empty_after",   70'(ms_to_ws_valid), 70'(0));

    // Hand-off with simultaneous accept of a load (op 6 behaves as ld.w), then a store.
    cyc(1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 32'h0000_0300), 1'b0, 1'b0, 32'h0);
    cyc(1'b1, mk(1'b1, 3'd6, 1'b1, 1'b1, 5'd9, 32'h0000_0040, 32'h0000_0304), 1'b1, 1'b0, 32'h0);
    check("ho_alu_valid",   70'(ms_to_ws_valid), 70'(1));
    check("ho_alu_bus",     ms_to_ws_bus, {1'b1, 5'd3, 32'hA5A5_A5A5, 32'h0000_0300});
    check("ho_allowin",     70'(ms_allowin),     70'(1));
    cyc(1'b1, mk(1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0000_0044, 32'h0000_0308), 1'b1, 1'b0, 32'h0);
    check("ho_ld_wait_valid",   70'(ms_to_ws_valid), 70'(0));
    check("ho_ld_wait_allowin", 70'(ms_allowin),     70'(0));
    check("ho_ld_wait_blocked", 70'(fwd_blocked),    70'(1));
    cyc(1'b1, mk(1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0000_0044, 32'h0000_0308), 1'b1, 1'b1, 32'hCAFE_F00D);
    check("ho_ld_bus",      ms_to_ws_bus, {1'b1, 5'd9, 32'hCAFE_F00D, 32'h0000_0304});
    check("ho_ld_allowin",  70'(ms_allowin),     70'(1));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("st_wait_valid",   70'(ms_to_ws_valid), 70'(0));
    check("st_wait_fwd_we",  70'(fwd_we),         70'(0));
    check("st_wait_blocked", 70'(fwd_blocked),    70'(0));
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h1111_2222);
    check("st_done_valid",  70'(ms_to_ws_valid), 70'(1));
    check("st_done_bus",    ms_to_ws_bus, {1'b0, 5'd0, 32'h0000_0044, 32'h0000_0308});
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("st_drained",     70'(ms_to_ws_valid), 70'(0));

    // Reset while a load waits for its response.
    cyc(1'b1, mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd4, 32'h0000_0080, 32'h0000_0400), 1'b1, 1'b0, 32'h0);
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("rw_pre_blocked", 70'(fwd_blocked), 70'(1));
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rw_valid",   70'(ms_to_ws_valid), 70'(0));
    check("rw_allowin", 70'(ms_allowin),     70'(1));
    check("rw_fwd_we",  70'(fwd_we),         70'(0));
    check("rw_blocked", 70'(fwd_blocked),    70'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd6, 32'h0BAD_CAFE, 32'h0000_0500), 1'b1, 1'b0, 32'h0);
    check("post_rst_allowin", 70'(ms_allowin),     70'(1));
    check("post_rst_valid",   70'(ms_to_ws_valid), 70'(0));
    cyc(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check("post_rst_bus",     ms_to_ws_bus, {1'b1, 5'd6, 32'h0BAD_CAFE, 32'h0000_0500});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ES_TO_MS_BUS_WD, default 75, es-to-ms bus width (shared constant).
REQ-002 SHALL have parameter MS_TO_WS_BUS_WD, default 70, ms-to-ws bus width (shared constant).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ms_allowin  output  1  stage accepts a new instruction this cycle.
REQ-006 es_to_ms_valid  input  1  upstream offers an instruction.
REQ-007 es_to_ms_bus  input  75  {req_issued[74], mem_op[73:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-008 ws_allowin  input  1  writeback accepts.
REQ-009 ms_to_ws_valid  output  1  stage offers a completed instruction.
REQ-010 ms_to_ws_bus  output  70  {reg_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-011 ms_to_es_bus  output  39  forwarding {fwd_we[38], fwd_blocked[37], dest[36:32], final_result[31:0]}.
REQ-012 data_sram_data_ok  input  1  one-cycle response pulse for an issued request.
REQ-013 data_sram_rdata  input  32  response data, valid with data_ok.

Function
REQ-014 Handshake: ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-015 On es_to_ms_valid && ms_allowin, bus SHALL be latched into ms_bus_r; ms_valid SHALL load es_to_ms_valid whenever ms_allowin.
REQ-016 Slot FSM states EMPTY, WAIT_RESP, READY: EMPTY->WAIT_RESP on accept with req_issued=1; EMPTY->READY on accept with req_issued=0.
REQ-017 WAIT_RESP->READY on data_sram_data_ok; WAIT_RESP with data_ok && ws_allowin SHALL pass through combinationally (ms_ready_go=1 same cycle).
REQ-018 READY->EMPTY on ws_allowin with no new accept; READY->WAIT_RESP/READY directly on simultaneous hand-off and accept (back-to-back, no bubble).
REQ-019 ms_ready_go = (state==READY) || (state==WAIT_RESP && data_sram_data_ok).
REQ-020 Response buffer: data_ok arriving while ws_allowin=0 SHALL capture rdata into 32-bit data_buf; final_result SHALL use data_buf in READY, live rdata in WAIT_RESP.
REQ-021 data_ok while state EMPTY or READY SHALL be ignored (no state or buffer change).
REQ-022 mem_op: 0 ld.w, 1 ld.b, 2 ld.h, 3 ld.bu, 4 ld.hu; 5-7 treated as ld.w.
REQ-023 Byte select by alu_result[1:0]; halfword select by alu_result[1]; .b/.h sign-extend, .bu/.hu zero-extend to 32 bits.
REQ-024 final_result = res_from_mem ? aligned load data : alu_result.
REQ-025 reg_we = gr_we; stores (req_issued=1, gr_we=0) complete on data_ok with no register effect.
REQ-026 fwd_we = ms_valid && gr_we; fwd_blocked = ms_valid && res_from_mem && !ms_ready_go (consumer stalls).
REQ-027 ms_to_ws_bus fields and ms_to_es_bus SHALL be driven from ms_bus_r, valid only when qualified by valid/fwd_we.

Reset
REQ-028 While reset high: ms_valid=0, state=EMPTY, ms_to_ws_valid=0, ms_allowin=1, fwd_we=0, fwd_blocked=0; data_buf and ms_bus_r unreset.
REQ-029 Reset mid-WAIT_RESP SHALL drop the instruction; the SRAM bridge shares this reset, so no stale data_ok follows.

Structure
REQ-030 ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_TO_ES_BUS_WD and mem_op encodings SHALL live in the shared mycpu header.
REQ-031 Load alignment/extension SHALL be one combinational sub-module, load_align.

Verification
REQ-032 ALU op pc=0x1c000000, res=0x12345678, ws_allowin=1 -> ms_to_ws_valid next cycle, bus {1,dest,0x12345678,pc}.
REQ-033 ld.b addr 0x...3, data_ok rdata=0x80FF_0000 same cycle as ws_allowin=1 -> final_result 0xFFFFFF80; ld.bu -> 0x00000080.
REQ-034 ld.hu addr 0x...2, data_ok after 3 wait cycles, ws_allowin=0 for 2 more -> data_buf holds rdata, result 0x000080FF emitted once ws_allowin=1.
REQ-035 Back-to-back ALU ops with ws_allowin=1 -> one instruction per cycle, ms_allowin never low.
REQ-036 Load waiting -> fwd_blocked=1 until data_ok; spurious data_ok in EMPTY -> no output change.
REQ-037 Reset asserted in WAIT_RESP -> ms_to_ws_valid=0 immediately, state EMPTY after release.
